// File: rtl/input_normalizer.sv
// Pre-normalizes an unsigned operand for a CORDIC square root: shifts left in bit
// pairs until one of the top two bits is set, and reports the pair count and a zero flag.
//
//   state | meaning
//   IDLE  | ready for an operand; registers hold the last result
//   NORM  | shifting the operand left two bits per cycle
//   DONE  | result presented to the CORDIC, waiting for out_rdy
module input_normalizer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_exp,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [3:0]         k_q, k_d;
    logic               zero_q, zero_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            k_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            k_q     <= k_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        k_d     = k_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_val) begin
                    data_d  = in_data;
                    k_d     = '0;
                    zero_d  = 1'b0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (data_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = DONE;
                // k stops at 7: any nonzero 16-bit operand is normalized by then
                end else if ((data_q[WIDTH-1:WIDTH-2] == 2'b00) && (k_q != 4'd7)) begin
                    data_d = {data_q[WIDTH-3:0], 2'b00};
                    k_d    = k_q + 4'd1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_rdy   = (state_q == IDLE);
    assign out_val  = (state_q == DONE);
    assign out_data = data_q;
    assign out_exp  = k_q;
    assign out_zero = zero_q;

endmodule

// File: tb/tb_input_normalizer.sv
// Directed bench for input_normalizer: table of operands with hand-computed shift
// counts and latencies, plus stall, ignored-input and mid-normalization reset sequences.
module tb_input_normalizer;

    logic        clk;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [15:0] in_data;
    logic        out_val;
    logic        out_rdy;
    logic [15:0] out_data;
    logic [3:0]  out_exp;
    logic        out_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] din;
        int          lat;
        logic [15:0] dout;
        logic [3:0]  kexp;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    input_normalizer #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_exp  (out_exp),
        .out_zero (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Capture on the next edge, then count edges until out_val (bounded at 20).
    task automatic run_vec(input logic [15:0] din, input int lat, input logic [15:0] dout,
                           input logic [3:0] kexp, input logic zero);
        int n;
        @(negedge clk);
        in_data = din;
        in_val  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_val  = 1'b0;
        in_data = 16'($urandom_range(0, 65535));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_val && n < 20);
        chk("latency", 32'(n), 32'(lat));
        chk("out_val", 32'(out_val), 32'd1);
        chk("in_rdy_busy", 32'(in_rdy), 32'd0);
        chk("out_data", 32'(out_data), 32'(dout));
        chk("out_exp", 32'(out_exp), 32'(kexp));
        chk("out_zero", 32'(out_zero), 32'(zero));
        @(posedge clk);
        #1;
        chk("handshake_val", 32'(out_val), 32'd0);
        chk("handshake_rdy", 32'(in_rdy), 32'd1);
    endtask

    initial begin
        int n;
        vecs[0] = '{16'hC000, 1, 16'hC000, 4'd0, 1'b0};
        vecs[1] = '{16'h0001, 8, 16'h4000, 4'd7, 1'b0};
        vecs[2] = '{16'h0300, 4, 16'hC000, 4'd3, 1'b0};
        vecs[3] = '{16'h0000, 1, 16'h0000, 4'd0, 1'b1};
        vecs[4] = '{16'h8000, 1, 16'h8000, 4'd0, 1'b0};
        vecs[5] = '{16'h0010, 6, 16'h4000, 4'd5, 1'b0};
        vecs[6] = '{16'h2000, 2, 16'h8000, 4'd1, 1'b0};
        vecs[7] = '{16'h3FFF, 2, 16'hFFFC, 4'd1, 1'b0};
        vecs[8] = '{16'h0002, 8, 16'h8000, 4'd7, 1'b0};
        vecs[9] = '{16'h4001, 1, 16'h4001, 4'd0, 1'b0};

        reset   = 1'b1;
        in_val  = 1'b0;
        in_data = 16'h0;
        out_rdy = 1'b1;
        #12;
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_exp", 32'(out_exp), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i].din, vecs[i].lat, vecs[i].dout, vecs[i].kexp, vecs[i].zero);
        end

        // Stall in DONE with in_val pulses of 0xFFFF that must not be captured.
        out_rdy = 1'b0;
        @(negedge clk);
        in_data = 16'h0010;
        in_val  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_val = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_val && n < 20);
        chk("stall_latency", 32'(n), 32'd6);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_val  = ~in_val;
            in_data = 16'hFFFF;
            @(posedge clk);
            #1;
            chk("stall_val", 32'(out_val), 32'd1);
            chk("stall_in_rdy", 32'(in_rdy), 32'd0);
            chk("stall_data", 32'(out_data), 32'h4000);
            chk("stall_exp", 32'(out_exp), 32'd5);
        end
        @(negedge clk);
        in_val  = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_val", 32'(out_val), 32'd0);
        chk("stall_release_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;
        chk("idle_hold_data", 32'(out_data), 32'h4000);
        chk("idle_hold_exp", 32'(out_exp), 32'd5);
        chk("idle_hold_rdy", 32'(in_rdy), 32'd1);

        // Asynchronous reset in the middle of normalizing 0x0001.
        @(negedge clk);
        in_data = 16'h0001;
        in_val  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_val = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_out_val", 32'(out_val), 32'd0);
        chk("arst_in_rdy", 32'(in_rdy), 32'd1);
        chk("arst_out_exp", 32'(out_exp), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_vec(16'h8000, 1, 16'h8000, 4'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_normalizer.md
INPUT_NORMALIZER -- requirements
Module: input_normalizer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the operand width in bits; only the value 16 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_val, input, 1 bit: upstream operand valid.
REQ-005 SHALL have port in_rdy, output, 1 bit: block can accept an operand.
REQ-006 SHALL have port in_data, input, WIDTH bits: unsigned operand whose square root is required.
REQ-007 SHALL have port out_val, output, 1 bit: normalized result valid; drives CORDIC operands_val.
REQ-008 SHALL have port out_rdy, output direction input, 1 bit: downstream CORDIC ready.
REQ-009 SHALL have port out_data, output, WIDTH bits: normalized operand, equal to in_data shifted left by 2*out_exp.
REQ-010 SHALL have port out_exp, output, 4 bits: shift-pair count k, range 0..7; the post-stage shifts the root right by k.
REQ-011 SHALL have port out_zero, output, 1 bit: captured operand was zero.

Function
REQ-012 SHALL implement an FSM with three states: IDLE, NORM and DONE.
REQ-013 SHALL assert in_rdy only in IDLE; SHALL assert out_val only in DONE.
REQ-014 In IDLE with in_val=1, SHALL on the rising edge capture in_data into data_reg, clear k and zero_reg, and go to NORM.
REQ-015 In IDLE with in_val=0, SHALL remain in IDLE with all registers held.
REQ-016 In NORM with data_reg=0, SHALL set zero_reg=1, hold k=0 and go to DONE.
REQ-017 In NORM with data_reg[15:14]=00 and data_reg nonzero, SHALL shift data_reg left by 2 with zero fill, increment k and stay in NORM.
REQ-018 In NORM with data_reg[15:14] not 00, SHALL go to DONE with data_reg and k unchanged.
REQ-019 Latency: for a nonzero operand, out_val SHALL rise on the (k+1)th rising edge after the capture edge.
REQ-020 Latency: for a zero operand, out_val SHALL rise on the 1st rising edge after the capture edge.
REQ-021 k SHALL never exceed 7; for any nonzero 16-bit input, normalization SHALL complete by k=7.
REQ-022 out_data, out_exp and out_zero SHALL be driven directly from data_reg, k and zero_reg.
REQ-023 In DONE, out_data, out_exp and out_zero SHALL be held stable while out_rdy=0.
REQ-024 In DONE, a handshake (out_val=1 and out_rdy=1) SHALL return the FSM to IDLE on that edge.
REQ-025 There SHALL be no back-to-back bypass; in_rdy SHALL rise one cycle after the output handshake.
REQ-026 in_val asserted outside IDLE SHALL be ignored, with no capture and no state change.
REQ-027 in_data SHALL be sampled only on the capture edge; later changes to in_data SHALL have no effect.

Reset
REQ-028 On reset=1, regardless of the clock, the block SHALL set state=IDLE and data_reg=0, k=0, zero_reg=0.
REQ-029 Output values during reset SHALL be in_rdy=1, out_val=0, out_data=0, out_exp=0, out_zero=0.
REQ-030 Reset asserted during NORM or DONE SHALL discard the operand in flight.
REQ-031 A new operand SHALL be accepted on the first rising edge after reset deasserts with in_val=1.

Verification
REQ-032 Scenario: in_data=0xC000, out_rdy=1 -> out_val on edge 1 after capture, out_data=0xC000, out_exp=0, out_zero=0.
REQ-033 Scenario: in_data=0x0001 -> out_val on edge 8 after capture, out_data=0x4000, out_exp=7.
REQ-034 Scenario: in_data=0x0300 -> out_val on edge 4 after capture, out_data=0xC000, out_exp=3.
REQ-035 Scenario: in_data=0x0000 -> out_val on edge 1 after capture, out_zero=1, out_data=0, out_exp=0.
REQ-036 Scenario: in_data=0x0010, out_rdy held 0 for 5 cycles in DONE, in_val toggled with 0xFFFF.
- Required response: out_data=0x4000 and out_exp=5 stay stable; in_rdy=0; the 0xFFFF pulses are not captured.
- After out_rdy=1: handshake, then in_rdy=1 on the next cycle.
REQ-037 Scenario: reset pulsed asynchronously (between clock edges) during NORM of 0x0001.
- Required response: out_val=0 and in_rdy=1 immediately.
- Next operand 0x8000: out_exp=0 with no residue from the discarded operand.
